// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared defaults and helpers for the stream_demux_1xn block.
//   DEMUX_DATA_W_DEF : default beat width
//   DEMUX_N_CH_DEF   : default number of output channels
//   sel_legal()      : true when a select value addresses an existing channel
// -----------------------------------------------------------------------------
package demux_pkg;

   localparam int DEMUX_DATA_W_DEF = 8;
   localparam int DEMUX_N_CH_DEF   = 8;

   // Selects are widened to 32 bits by the caller so one helper serves any SEL_W.
   function automatic logic sel_legal(input logic [31:0] sel, input logic [31:0] n);
      return sel < n;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry register slice holding a single beat for one output channel.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture data_i on this edge (only asserted while free_o = 1)
//   data_i       : beat payload to capture
//   out_ready_i  : downstream consumer accepts the held beat
//   out_valid_o  : a beat is held
//   out_data_o   : held beat payload, stable while out_valid_o && !out_ready_i
//   free_o       : slot can take a beat this cycle (empty, or draining now)
// -----------------------------------------------------------------------------
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = DEMUX_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              out_ready_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              free_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // A full slot that drains this cycle can be refilled in the same cycle.
   assign free_o = !valid_q || out_ready_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         // NOTE: the data register is reset too, because out_data must read zero after reset.
         data_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// stream_demux_1xn
// Registered 1-to-N stream demultiplexer. Each accepted beat is steered by
// in_sel into a one-entry slot on the chosen channel; every channel drains
// independently under its own backpressure. Beats with in_sel >= N_CH are
// accepted, discarded and flagged on drop_pulse for one cycle.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake
//   in_data, in_sel        : input payload and destination channel
//   out_valid/out_ready    : per-channel output handshake (N_CH bits)
//   out_data               : channel c at [c*DATA_W +: DATA_W]
//   drop_pulse             : an illegal-select beat was discarded last cycle
//   in_bcast               : (DEMUX_BCAST_EN only) load the beat into every channel
// Configuration macro: DEMUX_BCAST_EN adds the in_bcast port and broadcast mode.
// -----------------------------------------------------------------------------
module stream_demux_1xn
   import demux_pkg::*;
#(
   parameter  int DATA_W = DEMUX_DATA_W_DEF,
   parameter  int N_CH   = DEMUX_N_CH_DEF,
   localparam int SEL_W  = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
   input  logic                     in_bcast,
`endif
   output logic [N_CH-1:0]          out_valid,
   input  logic [N_CH-1:0]          out_ready,
   output logic [N_CH*DATA_W-1:0]   out_data,
   output logic                     drop_pulse
);

   logic [N_CH-1:0] slot_free;
   logic [N_CH-1:0] load_vec;
   logic            sel_ok;
   logic            sel_free;
   logic            accept;
   logic            bcast;
   logic            drop_q, drop_d;

`ifdef DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign sel_ok = sel_legal(32'(in_sel), 32'(N_CH));

   // Ready decode is independent of in_valid; illegal selects are always
   // accepted so a bad beat can never stall the producer.
   always_comb begin
      sel_free = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if (in_sel == SEL_W'(c)) sel_free = slot_free[c];
      end

      if (bcast)       in_ready = &slot_free;
      else if (sel_ok) in_ready = sel_free;
      else             in_ready = 1'b1;

      accept = in_valid && in_ready;

      load_vec = '0;
      for (int c = 0; c < N_CH; c++) begin
         load_vec[c] = accept && (bcast || (in_sel == SEL_W'(c)));
      end

      drop_d = accept && !bcast && !sel_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_q <= 1'b0;
      else        drop_q <= drop_d;
   end

   assign drop_pulse = drop_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_slot
      demux_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .load_i      (load_vec[c]),
         .data_i      (in_data),
         .out_ready_i (out_ready[c]),
         .out_valid_o (out_valid[c]),
         .out_data_o  (out_data[c*DATA_W +: DATA_W]),
         .free_o      (slot_free[c])
      );
   end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1xn
// Directed bench for stream_demux_1xn: an 8-channel instance for the main
// behaviour and a 6-channel instance for illegal-select handling.
// Broadcast checks are compiled in when DEMUX_BCAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_demux_1xn;

   localparam int DW = 8;

   logic           clk = 1'b0;
   logic           rst_n;

   // 8-channel instance
   logic           in_valid, in_ready;
   logic [DW-1:0]  in_data;
   logic [2:0]     in_sel;
   logic [7:0]     out_valid, out_ready;
   logic [8*DW-1:0] out_data;
   logic           drop_pulse;
   logic           in_bcast;

   // 6-channel instance
   logic           in_valid6, in_ready6;
   logic [DW-1:0]  in_data6;
   logic [2:0]     in_sel6;
   logic [5:0]     out_valid6, out_ready6;
   logic [6*DW-1:0] out_data6;
   logic           drop_pulse6;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stream_demux_1xn #(.DATA_W(DW), .N_CH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
`ifdef DEMUX_BCAST_EN
      .in_bcast   (in_bcast),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .drop_pulse (drop_pulse)
   );

   stream_demux_1xn #(.DATA_W(DW), .N_CH(6)) dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid6),
      .in_ready   (in_ready6),
      .in_data    (in_data6),
      .in_sel     (in_sel6),
`ifdef DEMUX_BCAST_EN
      .in_bcast   (1'b0),
`endif
      .out_valid  (out_valid6),
      .out_ready  (out_ready6),
      .out_data   (out_data6),
      .drop_pulse (drop_pulse6)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] ch(input int c);
      return out_data[c*DW +: DW];
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_sel     = '0;
      in_bcast   = 1'b0;
      out_ready  = 8'hFF;
      in_valid6  = 1'b0;
      in_data6   = '0;
      in_sel6    = '0;
      out_ready6 = 6'h3F;

      // Reset state
      #2;
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_data",  out_data, 64'h0);
      check("rst_drop",  64'(drop_pulse), 64'h0);
      step();
      rst_n = 1'b1;

      // Sweep: one beat per channel, consumers always ready
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         in_sel   = 3'(i);
         #1;
         check($sformatf("sweep_ready_%0d", i), 64'(in_ready), 64'h1);
         step();
         check($sformatf("sweep_valid_%0d", i), 64'(out_valid), 64'(8'h01 << i));
         check($sformatf("sweep_data_%0d", i), 64'(ch(i)), 64'(8'hA0 + i));
         check($sformatf("sweep_drop_%0d", i), 64'(drop_pulse), 64'h0);
      end
      in_valid = 1'b0;
      step();
      check("sweep_empty", 64'(out_valid), 64'h0);

      // Backpressure on channel 3
      out_ready = 8'hF7;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      in_sel    = 3'd3;
      #1;
      check("bp_ready_first", 64'(in_ready), 64'h1);
      step();
      check("bp_valid_first", 64'(out_valid), 64'h08);
      check("bp_data_first",  64'(ch(3)), 64'h11);
      in_data = 8'h22;
      #1;
      check("bp_ready_stall", 64'(in_ready), 64'h0);
      step();
      check("bp_hold_valid", 64'(out_valid), 64'h08);
      check("bp_hold_data",  64'(ch(3)), 64'h11);
      check("bp_ready_still", 64'(in_ready), 64'h0);
      out_ready = 8'hFF;
      #1;
      check("bp_ready_drain", 64'(in_ready), 64'h1);
      step();
      check("bp_refill_valid", 64'(out_valid), 64'h08);
      check("bp_refill_data",  64'(ch(3)), 64'h22);
      in_valid = 1'b0;
      step();
      check("bp_empty", 64'(out_valid), 64'h0);

      // Drain and refill in the same cycle on channel 1
      out_ready = 8'hFD;
      in_valid  = 1'b1;
      in_data   = 8'h33;
      in_sel    = 3'd1;
      step();
      check("dr_valid_first", 64'(out_valid), 64'h02);
      check("dr_data_first",  64'(ch(1)), 64'h33);
      out_ready = 8'hFF;
      in_data   = 8'h44;
      #1;
      check("dr_ready", 64'(in_ready), 64'h1);
      step();
      check("dr_valid_refill", 64'(out_valid), 64'h02);
      check("dr_data_refill",  64'(ch(1)), 64'h44);
      in_valid = 1'b0;
      step();
      check("dr_empty", 64'(out_valid), 64'h0);

      // Illegal select on the 6-channel instance
      in_valid6 = 1'b1;
      in_data6  = 8'h55;
      in_sel6   = 3'd7;
      #1;
      check("ill_ready", 64'(in_ready6), 64'h1);
      step();
      check("ill_drop_hi", 64'(drop_pulse6), 64'h1);
      check("ill_valid",   64'(out_valid6), 64'h0);
      in_sel6 = 3'd6;
      step();
      check("ill6_drop_hi", 64'(drop_pulse6), 64'h1);
      in_valid6 = 1'b0;
      step();
      check("ill_drop_lo", 64'(drop_pulse6), 64'h0);
      check("ill_valid_lo", 64'(out_valid6), 64'h0);
      in_valid6 = 1'b1;
      in_data6  = 8'h5A;
      in_sel6   = 3'd5;
      step();
      check("leg6_valid", 64'(out_valid6), 64'h20);
      check("leg6_data",  64'(out_data6[5*DW +: DW]), 64'h5A);
      check("leg6_drop",  64'(drop_pulse6), 64'h0);
      in_valid6 = 1'b0;
      step();

`ifdef DEMUX_BCAST_EN
      // Broadcast blocked by a full, stalled channel 4
      out_ready = 8'h10 ^ 8'hFF;
      in_valid  = 1'b1;
      in_data   = 8'h40;
      in_sel    = 3'd4;
      step();
      check("bc_fill4", 64'(out_valid), 64'h10);
      in_bcast = 1'b1;
      in_data  = 8'h77;
      in_sel   = 3'd7;
      #1;
      check("bc_ready_stall", 64'(in_ready), 64'h0);
      step();
      check("bc_hold_valid", 64'(out_valid), 64'h10);
      check("bc_hold_data",  64'(ch(4)), 64'h40);
      out_ready = 8'h10;
      #1;
      check("bc_ready_go", 64'(in_ready), 64'h1);
      step();
      check("bc_valid_all", 64'(out_valid), 64'hFF);
      check("bc_data_all",  out_data, 64'h7777_7777_7777_7777);
      check("bc_no_drop",   64'(drop_pulse), 64'h0);
      in_valid  = 1'b0;
      in_bcast  = 1'b0;
      out_ready = 8'hFF;
      step();
      check("bc_empty", 64'(out_valid), 64'h0);
`endif

      // Asynchronous reset mid-stream with channels 2 and 5 full
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'h62;
      in_sel    = 3'd2;
      step();
      in_data = 8'h65;
      in_sel  = 3'd5;
      step();
      check("ar_full", 64'(out_valid), 64'h24);
      check("ar_data5", 64'(ch(5)), 64'h65);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(out_valid), 64'h0);
      check("ar_data",  out_data, 64'h0);
      check("ar_drop",  64'(drop_pulse), 64'h0);
      step();
      rst_n = 1'b1;
      out_ready = 8'hFF;
      step();
      check("ar_after", 64'(out_valid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Parametrised registered 1-to-N stream demultiplexer with valid/ready handshake.
- Each input beat is routed by a per-beat select into a one-entry holding slot on the chosen output channel.
- Each channel drains independently under backpressure from its own consumer.
- Successor to the fixed-width combinational 1x2/1x4/1x8 demux tree; used wherever one producer feeds N stalling consumers.

Parameters:
- DATA_W, 8, width of each data beat.
- N_CH, 8, number of output channels; any value >= 2, need not be a power of two.
- SEL_W, $clog2(N_CH), select width; localparam, derived, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  DATA_W  input beat payload.
- in_sel  input  SEL_W  destination channel index for the current beat.
- out_valid  output  N_CH  per-channel beat held.
- out_ready  input  N_CH  per-channel consumer accepts.
- out_data  output  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- drop_pulse  output  1  one-cycle flag: an illegal-select beat was discarded.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid = 0, out_data = 0, drop_pulse = 0. Assertion mid-operation discards all held beats immediately, without waiting for a clock edge.
- Per-channel state: one slot per channel, i.e. a valid bit plus a DATA_W register.
- Slot free condition: slot_free[c] = !out_valid[c] || out_ready[c]. A full slot being drained this cycle may be refilled in the same cycle.
- Ready: in_ready = slot_free[in_sel] when in_sel < N_CH, else 1.
  - Combinational from in_sel, out_valid and out_ready.
  - Does not depend on in_valid.
- Accept: in_valid && in_ready.
  - Legal select: on the next edge, out_valid[in_sel] = 1 and that channel's out_data = in_data.
  - Latency is exactly 1 cycle.
- Illegal select (in_sel >= N_CH, possible only for non-power-of-2 N_CH): beat is accepted and discarded; drop_pulse = 1 on the next cycle only.
- Drain: out_ready[c] && out_valid[c] with no refill clears out_valid[c] on the next edge.
  - Same-cycle drain and refill keeps out_valid[c] = 1 and loads the new data.
- Stability: while out_valid[c] && !out_ready[c], out_data for channel c is held stable. Unselected channels' data and valid bits are never disturbed.
- Throughput: 1 beat/cycle sustained when the destination consumer holds ready high.
- Concurrency: different channels may drain in the same cycle while another is loaded; there is no ordering between channels.
- Back-to-back beats to a stalled channel: in_ready = 0 until that slot frees.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined: adds input port in_bcast (1 bit).
  - When in_bcast = 1: in_ready = AND of all slot_free bits.
  - On accept, every channel loads in_data and sets out_valid.
  - in_sel is ignored; drop_pulse is never raised for a broadcast beat.
- Undefined: port absent; unicast-only behaviour exactly as above.

Decomposition:
- Package demux_pkg:
  - Default DATA_W/N_CH constants.
  - Function sel_legal(sel, n) returning sel < n.
- Sub-module demux_slot: one-entry register slice with load, data_in, out_valid, out_ready, out_data and free output. Instantiated N_CH times by a generate loop.
- Top module holds ready/accept decode, drop_pulse register and broadcast logic.

Test Plan:
- Reset: rst_n = 0 mid-stream with channels 2 and 5 full -> out_valid = 8'h00 and out_data = 0 before the next edge; drop_pulse = 0.
- Sweep: DATA_W = 8, N_CH = 8, out_ready all 1; send data 8'hA0+i with sel = i for i = 0..7 on consecutive cycles -> one cycle later out_valid = 1<<i and channel i data = 8'hA0+i; in_ready stays 1.
- Backpressure: out_ready[3] = 0; send 8'h11 then 8'h22 to sel 3 -> first accepted; in_ready = 0 on the second until out_ready[3] rises; channel 3 holds 8'h11; 8'h22 appears the cycle after the drain.
- Drain+refill: channel 1 full with 8'h33, out_ready[1] = 1, new beat 8'h44 to sel 1 same cycle -> out_valid[1] stays 1 and data becomes 8'h44 next cycle.
- Illegal select: N_CH = 6, sel = 7, data 8'h55 -> in_ready = 1; accepted; drop_pulse high exactly one cycle; no out_valid change.
- Broadcast (DEMUX_BCAST_EN): in_bcast = 1, data 8'h77, channel 4 stalled and full -> in_ready = 0; after the drain, all 8 channels show 8'h77 with out_valid = 8'hFF.
